// File: rtl/spongent_perm_arbiter_pkg.sv
// Shared constants and FSM encoding for the Spongent permutation arbiter.
package spongent_perm_arbiter_pkg;

    localparam int SPONGENT_B    = 264;
    localparam int SPONGENT_RATE = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } arb_state_e;

    // Watchdog width; a disabled watchdog still keeps a 1-bit counter so ports stay legal.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/spongent_perm_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

    int sum;
    int cand;

    // Scan requesters in rotated order and keep the first hit.
    always_comb begin
        win_any    = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        sum        = 0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            sum  = int'(ptr) + k;
            cand = (sum >= N_REQ) ? (sum - N_REQ) : sum;
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(cand);
            end else begin
                win_any = win_any;
            end
        end
        if (win_any) begin
            win_onehot[win_idx] = 1'b1;
        end else begin
            win_onehot = '0;
        end
    end

endmodule

// File: rtl/spongent_perm_arbiter.sv
// Shares one Spongent permutation core between N_REQ requesters with round-robin
// grants, the core's en/rst/rdy handshake, and a watchdog that aborts hung jobs.
module spongent_perm_arbiter
    import spongent_perm_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int STATE_W = SPONGENT_B,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*STATE_W-1:0] req_state,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [STATE_W-1:0]       rsp_state,
    output logic                     err_timeout,
    output logic [STATE_W-1:0]       perm_state_in,
    output logic                     perm_en,
    output logic                     perm_rst,
    input  logic                     perm_rdy,
    input  logic [STATE_W-1:0]       perm_state_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = wdog_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    arb_state_e         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   wdog_cnt;
    logic [N_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [STATE_W-1:0] win_state;
    logic [IDX_W-1:0]   next_ptr;
    logic               wdog_expired;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req        (req),
        .ptr        (rr_ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_any    (win_any)
    );

    assign win_state    = req_state[int'(win_idx)*STATE_W +: STATE_W];
    assign next_ptr     = (win_idx == LAST_IDX) ? '0 : (win_idx + IDX_W'(1));
    assign wdog_expired = (TIMEOUT != 0) && (wdog_cnt == CNT_LIMIT);
    // The core is held in reset both by the system reset and for one cycle between jobs.
    assign perm_rst     = rst | (state == ST_CLEAR);

    // Job sequencer: grant, run the core, deliver or abort, then scrub the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            wdog_cnt      <= '0;
            gnt           <= '0;
            rsp_valid     <= '0;
            rsp_state     <= '0;
            err_timeout   <= 1'b0;
            perm_state_in <= '0;
            perm_en       <= 1'b0;
        end else begin
            rsp_valid   <= '0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        gnt           <= win_onehot;
                        perm_state_in <= win_state;
                        rr_ptr        <= next_ptr;
                        wdog_cnt      <= CNT_W'(1);
                        perm_en       <= 1'b1;
                        state         <= ST_BUSY;
                    end else begin
                        gnt     <= '0;
                        perm_en <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // A result arriving on the last allowed cycle still beats the watchdog.
                    if (perm_rdy) begin
                        rsp_state <= perm_state_out;
                        rsp_valid <= gnt;
                        state     <= ST_DONE;
                    end else if (wdog_expired) begin
                        err_timeout <= 1'b1;
                        gnt         <= '0;
                        perm_en     <= 1'b0;
                        wdog_cnt    <= '0;
                        state       <= ST_CLEAR;
                    end else begin
                        wdog_cnt <= (wdog_cnt == CNT_MAX) ? wdog_cnt : (wdog_cnt + CNT_W'(1));
                    end
                end
                ST_DONE: begin
                    gnt      <= '0;
                    perm_en  <= 1'b0;
                    wdog_cnt <= '0;
                    state    <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    gnt      <= '0;
                    perm_en  <= 1'b0;
                    wdog_cnt <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    gnt      <= '0;
                    perm_en  <= 1'b0;
                    wdog_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spongent_perm_arbiter.sv
// Scoreboard bench: stimulus queues expected jobs from a round-robin reference,
// a negedge monitor pops and checks grants, results, aborts and timing.
module tb_spongent_perm_arbiter;

    localparam int N    = 2;
    localparam int W    = 264;
    localparam int TO   = 8;
    localparam int HANG = 255;

    typedef struct {
        int           idx;
        logic [W-1:0] sin;
        logic [W-1:0] sout;
        int           lat;
        bit           timeout;
    } job_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_state;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_state;
    logic           err_timeout;
    logic [W-1:0]   perm_state_in;
    logic           perm_en;
    logic           perm_rst;
    logic           perm_rdy = 1'b0;
    logic [W-1:0]   perm_state_out;

    logic [N-1:0] req_mask  = '0;
    logic [N-1:0] done_mask = '0;
    logic [N-1:0] hold_mask = '0;
    logic [W-1:0] st_val [N];

    job_t exp_q [$];
    int   lat_q [$];
    int   checks = 0;
    int   passes = 0;
    int   resp_count = 0;
    int   p = 0;

    spongent_perm_arbiter #(.N_REQ(N), .STATE_W(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_state      (req_state),
        .gnt            (gnt),
        .rsp_valid      (rsp_valid),
        .rsp_state      (rsp_state),
        .err_timeout    (err_timeout),
        .perm_state_in  (perm_state_in),
        .perm_en        (perm_en),
        .perm_rst       (perm_rst),
        .perm_rdy       (perm_rdy),
        .perm_state_out (perm_state_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] absorb(input logic [W-1:0] s);
        return {s[W-8:0], s[W-1:W-7]} ^ {33{8'h5A}};
    endfunction

    assign req = req_mask & ~(done_mask & ~hold_mask);
    for (genvar g = 0; g < N; g++) begin : g_st
        assign req_state[g*W +: W] = st_val[g];
    end
    assign perm_state_out = absorb(perm_state_in);

    task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] rand_state();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    task automatic push_job(input int idx, input int lat);
        job_t j;
        j.idx     = idx;
        j.sin     = st_val[idx];
        j.sout    = absorb(st_val[idx]);
        j.lat     = lat;
        j.timeout = (lat > TO - 1);
        exp_q.push_back(j);
        lat_q.push_back(lat);
        p = (idx + 1) % N;
    endtask

    task automatic wait_resp(input int target, input int budget);
        int k = 0;
        while (resp_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(resp_count >= target, "resp_wait", W'(resp_count), W'(target));
    endtask

    // Stateful core model: rdy rises lat cycles into the job; HANG never completes in time.
    int  cur_lat = 0;
    int  acyc = 0;
    bit  active = 1'b0;
    always @(negedge clk) begin
        if (perm_rst || !perm_en) begin
            active   = 1'b0;
            perm_rdy = 1'b0;
        end else begin
            if (!active) begin
                active  = 1'b1;
                acyc    = 0;
                cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : HANG;
            end else begin
                acyc++;
            end
            perm_rdy = (acyc >= cur_lat);
        end
    end

    // Monitor: pops the scoreboard on grants, results and aborts.
    int         cyc = 0;
    int         grant_cyc = 0;
    int         end_cyc = 0;
    logic [N-1:0] prev_gnt = '0;
    bit         after_rsp = 1'b0;
    bit         b2b_pend = 1'b0;
    always @(negedge clk) begin
        job_t e;
        cyc++;
        if (req_mask == '0) done_mask = '0;
        if (hold_mask == '0) b2b_pend = 1'b0;
        if (rst) begin
            prev_gnt  = '0;
            after_rsp = 1'b0;
            b2b_pend  = 1'b0;
        end else begin
            if (after_rsp) begin
                chk(perm_rst && gnt == '0, "clear_after_rsp", W'({perm_rst, gnt}), W'(4));
                after_rsp = 1'b0;
            end
            if (gnt != '0 && prev_gnt == '0) begin
                chk($onehot(gnt), "gnt_onehot", W'(gnt), W'(0));
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_grant", W'(gnt), W'(0));
                end else begin
                    chk(gnt == (N'(1) << exp_q[0].idx), "grant_order", W'(gnt), W'(N'(1) << exp_q[0].idx));
                    chk(perm_state_in == exp_q[0].sin, "perm_state_in", perm_state_in, exp_q[0].sin);
                    chk(perm_en, "perm_en_busy", W'(perm_en), W'(1));
                    if (b2b_pend) chk(cyc - end_cyc == 3, "b2b_regrant_gap", W'(cyc - end_cyc), W'(3));
                end
                b2b_pend  = 1'b0;
                grant_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_rsp", W'(rsp_valid), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk(!e.timeout, "rsp_not_abort", W'(rsp_valid), W'(0));
                    chk(rsp_valid == (N'(1) << e.idx), "rsp_valid_owner", W'(rsp_valid), W'(N'(1) << e.idx));
                    chk(rsp_state == e.sout, "rsp_state", rsp_state, e.sout);
                    chk(cyc - grant_cyc == e.lat + 1, "rsp_latency", W'(cyc - grant_cyc), W'(e.lat + 1));
                    done_mask[e.idx] = 1'b1;
                    if (hold_mask[e.idx]) b2b_pend = 1'b1;
                end
                end_cyc   = cyc;
                after_rsp = 1'b1;
                resp_count++;
            end
            if (err_timeout) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_abort", W'(1), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk(e.timeout, "abort_expected", W'(0), W'(1));
                    chk(rsp_valid == '0, "abort_no_rsp", W'(rsp_valid), W'(0));
                    chk(cyc - grant_cyc == TO, "abort_latency", W'(cyc - grant_cyc), W'(TO));
                    chk(perm_rst && gnt == '0, "abort_clear", W'({perm_rst, gnt}), W'(4));
                    done_mask[e.idx] = 1'b1;
                end
                resp_count++;
            end
            prev_gnt = gnt;
        end
    end

    task automatic run_round(input logic [N-1:0] mask, input int force_lat);
        int n = 0;
        int start = p;
        int lat;
        for (int k = 0; k < N; k++) begin
            int i = (start + k) % N;
            if (mask[i]) begin
                st_val[i] = rand_state();
                lat = (force_lat > 0) ? force_lat
                    : (($urandom_range(0, 6) == 0) ? HANG : int'($urandom_range(1, 7)));
                push_job(i, lat);
                n++;
            end
        end
        req_mask = mask;
        wait_resp(resp_count + n, 40 * n);
        req_mask = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int k;
        for (int i = 0; i < N; i++) st_val[i] = '0;
        repeat (3) @(negedge clk);
        chk(gnt == '0 && rsp_valid == '0 && !err_timeout && !perm_en, "reset_ctrl",
            W'({gnt, rsp_valid, err_timeout, perm_en}), W'(0));
        chk(rsp_state == '0 && perm_state_in == '0, "reset_data", rsp_state | perm_state_in, W'(0));
        chk(perm_rst, "reset_perm_rst", W'(perm_rst), W'(1));
        rst = 1'b0;
        @(negedge clk);
        chk(!perm_rst, "idle_perm_rst", W'(perm_rst), W'(0));

        // Contention: both held for four jobs, grants alternate starting at requester 0.
        st_val[0] = rand_state();
        st_val[1] = rand_state();
        for (int j = 0; j < 4; j++) push_job(j % 2, int'($urandom_range(1, 6)));
        hold_mask = 2'b11;
        req_mask  = 2'b11;
        wait_resp(resp_count + 4, 200);
        req_mask  = '0;
        hold_mask = '0;
        repeat (4) @(negedge clk);

        // Single job with the literal state 1 and five-cycle core latency.
        st_val[0] = 264'h1;
        push_job(0, 5);
        req_mask = 2'b01;
        @(negedge clk);
        chk(gnt == 2'b01 && perm_en, "single_grant_next_cycle", W'({gnt, perm_en}), W'(3));
        wait_resp(resp_count + 1, 40);
        req_mask = '0;
        repeat (4) @(negedge clk);

        // Reset mid-job: pointer is 1 here, so the aborted job belongs to requester 1.
        st_val[0] = rand_state();
        st_val[1] = rand_state();
        push_job(1, HANG);
        req_mask = 2'b11;
        k = 0;
        while (gnt == '0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(gnt == 2'b10, "pre_reset_grant", W'(gnt), W'(2));
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        req_mask = '0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        chk(gnt == '0 && rsp_valid == '0 && !err_timeout && !perm_en && perm_rst, "midjob_reset_ctrl",
            W'({gnt, rsp_valid, err_timeout, perm_en, perm_rst}), W'(1));
        chk(rsp_state == '0 && perm_state_in == '0, "midjob_reset_data", rsp_state | perm_state_in, W'(0));
        rst = 1'b0;
        p   = 0;
        repeat (2) @(negedge clk);
        run_round(2'b11, 3);

        // Back-to-back: requester 1 keeps req high through CLEAR.
        st_val[1] = rand_state();
        push_job(1, 3);
        push_job(1, 2);
        hold_mask = 2'b10;
        req_mask  = 2'b10;
        wait_resp(resp_count + 2, 80);
        req_mask  = '0;
        hold_mask = '0;
        repeat (4) @(negedge clk);

        // Watchdog: hung core aborts, then rdy exactly on the last cycle still delivers.
        run_round(2'b01, HANG);
        run_round(2'b10, TO - 1);

        for (int r = 0; r < 20; r++) run_round(N'($urandom_range(1, 3)), 0);

        chk(exp_q.size() == 0, "scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
